// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
package hazard_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int MD_CNT_W        = 6;
    localparam int STALL_CNT_W     = 16;
    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    // r0 is hardwired zero, so a write to it never creates a dependency
    function automatic logic regMatch(
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt
    );
        return (dst != '0) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - multiply/divide occupancy counter with completion pulse
module md_busy_timer
    import hazard_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] loadVal,
    input  logic                busy,
    output logic                mdDone
);

    logic [MD_CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (busy && (cnt != '0)) begin
            cnt <= cnt - MD_CNT_W'(1);
        end
    end

    assign mdDone = busy && (cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard detection, stall/flush and mul/div occupancy FSM
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [REG_ADDR_W-1:0]  RsAddr_D,
    input  logic [REG_ADDR_W-1:0]  RtAddr_D,
    input  logic                   IsBranch_D,
    input  logic                   IsMulDiv_D,
    input  logic                   IsDiv_D,
    input  logic                   ReadHiLo_D,
    input  logic                   BranchTaken_D,
    input  logic                   MemRead_E,
    input  logic                   RegWriteEN_E,
    input  logic [REG_ADDR_W-1:0]  RegDstAddr_E,
    input  logic                   MemRead_M,
    input  logic [REG_ADDR_W-1:0]  RegDstAddr_M,
    output logic                   STALL,
    output logic                   FlushE,
    output logic                   FlushD,
    output logic                   MulDivBusy,
    output logic                   MdDone,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    mdState_t            state;
    mdState_t            stateNext;
    logic                loadHaz;
    logic                brExHaz;
    logic                brLoadHaz;
    logic                mdHaz;
    logic                mdIssue;
    logic                mdDone;
    logic [MD_CNT_W-1:0] loadVal;

    assign loadHaz   = MemRead_E && regMatch(RegDstAddr_E, RsAddr_D, RtAddr_D);
    assign brExHaz   = IsBranch_D && RegWriteEN_E && regMatch(RegDstAddr_E, RsAddr_D, RtAddr_D);
    assign brLoadHaz = IsBranch_D && MemRead_M && regMatch(RegDstAddr_M, RsAddr_D, RtAddr_D);
    // The completion cycle still counts as busy, which keeps mul/div issues from overlapping
    assign mdHaz     = (state == MD_BUSY) && (ReadHiLo_D || IsMulDiv_D);

    assign STALL  = RST_N && (loadHaz || brExHaz || brLoadHaz || mdHaz);
    assign FlushE = STALL;
    assign FlushD = RST_N && BranchTaken_D && !STALL;

    assign mdIssue = (state == RUN) && IsMulDiv_D && !STALL;
    assign loadVal = IsDiv_D ? MD_CNT_W'(DIV_CYCLES - 1) : MD_CNT_W'(MULT_CYCLES - 1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (mdIssue) stateNext = MD_BUSY;
            MD_BUSY: if (mdDone)  stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    md_busy_timer u_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .load    (mdIssue),
        .loadVal (loadVal),
        .busy    (state == MD_BUSY),
        .mdDone  (mdDone)
    );

    assign MulDivBusy = (state == MD_BUSY);
    assign MdDone     = mdDone;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            StallCnt <= '0;
        end else if (STALL && (StallCnt != '1)) begin
            StallCnt <= StallCnt + STALL_CNT_W'(1);
        end
    end

endmodule
